mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  Iterative multiply/divide controller for the EX stage of the pipelined proc; sequences a shared
//  shift/add-sub datapath for MULT/MULTU/DIV/DIVU and owns the HI/LO registers.
//  Works beside the ALU (ALUcontrol decode unchanged); EX decode raises start for these functs
//  and holds the pipeline while stall is high.
// PARAMETERS
//  WIDTH  32  operand width; iteration count = WIDTH
// PORTS
//  clk          in   1      rising-edge clock, the only clock
//  reset_n      in   1      synchronous, active-low reset
//  start        in   1      EX holds an MDU instruction this cycle
//  funct        in   6      MIPS funct: MULT 011000, MULTU 011001, DIV 011010, DIVU 011011,
//                           MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011
//  op_a         in   WIDTH  rs value (multiplicand/dividend, MTHI/MTLO data)
//  op_b         in   WIDTH  rt value (multiplier/divisor)
//  busy         out  1      iteration in progress
//  stall        out  1      combinational: start && (busy || state!=IDLE); hold EX
//  done         out  1      one-cycle pulse, HI/LO just updated by mult/div
//  div_by_zero  out  1      pulses with done when a DIV/DIVU had op_b==0
//  hi           out  WIDTH  HI register (MFHI reads it directly)
//  lo           out  WIDTH  LO register (MFLO reads it directly)
// BEHAVIOUR
//  - Reset (reset_n==0 at edge): state=IDLE, hi=lo=0, busy=done=div_by_zero=0, counter=0.
//    Applies mid-operation; the op is abandoned, no done pulse.
//  - States: IDLE -> MUL|DIV (WIDTH cycles) -> FIXUP (1 cycle) -> IDLE.
//  - IDLE + start + MULT/MULTU/DIV/DIVU: latch op_a/op_b magnitudes (signed ops: abs value; result
//    sign and remainder sign recorded), counter=WIDTH-1, go MUL/DIV; busy=1 from next cycle.
//  - IDLE + start + MTHI/MTLO: hi/lo <= op_a at that edge; no state change, no done.
//  - IDLE + start + MFHI/MFLO or any other funct: no state change (reads are combinational).
//  - MUL: 1 shift-add step per cycle, 2*WIDTH product accumulator. DIV: 1 restoring step per cycle
//    (shift remainder, trial subtract, set quotient bit). Counter decrements; at 0 -> FIXUP.
//  - DIV/DIVU with op_b==0: skip iteration, IDLE -> FIXUP directly; result hi=op_a, lo=all ones,
//    div_by_zero=1 with done.
//  - FIXUP: apply two's-complement negation of product/quotient per recorded sign; remainder takes
//    dividend sign. On the edge leaving FIXUP: hi/lo written, done=1 (next cycle only), busy=0.
//  - Latency: start edge = cycle 0; done high in cycle WIDTH+2 (34 for WIDTH=32); /0 in cycle 2.
//  - Overflow DIV 0x80000000/-1: lo=0x80000000, hi=0 (falls out of magnitude method; no flag).
//  - start while busy/FIXUP: stall=1, request ignored; EX re-presents it; accepted on first IDLE
//    cycle (the done cycle is IDLE, so back-to-back issue is legal there).
//  - MFHI/MFLO while busy: stall=1 (old HI/LO must not be read mid-op).
//  - hi/lo change only on MTHI/MTLO, FIXUP exit, or reset.
// STRUCTURE
//  - Shared package (proc_pkg): MDU funct localparams, state encoding (IDLE/MUL/DIV/FIXUP).
//  - One sub-module natural: mdu_datapath (accumulator/remainder shift regs, WIDTH+1-bit adder/sub,
//    negate logic); mult_div_unit keeps FSM, counter, sign flags, HI/LO.
// TESTING
//  1 MULT 7 x 0xFFFFFFFD(-3) -> done cycle 34, hi=0xFFFFFFFF lo=0xFFFFFFEB, busy cycles 1..33.
//  2 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE lo=0x00000001.
//  3 DIV 0xFFFFFFF9(-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/7 -> lo=14 hi=2.
//  4 DIVU 0x1234 / 0 -> done cycle 2, div_by_zero=1, hi=0x1234 lo=0xFFFFFFFF;
//    DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000 hi=0.
//  5 start MULT at cycle 5 of a running MULT -> stall=1, hi/lo unchanged; second op issued on done
//    cycle completes 34 cycles later; MTLO op_a=0xABCD in IDLE -> lo=0xABCD next cycle, done=0.
//  6 reset_n=0 at cycle 10 of MULT -> next cycle busy=0, hi=lo=0, no done pulse ever.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: MIPS funct codes,
// controller state encoding and a small decode helper.
package mult_div_unit_pkg;

    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_MUL   = 2'b01,
        ST_DIV   = 2'b10,
        ST_FIXUP = 2'b11
    } mdu_state_e;

    function automatic logic is_signed_op(input logic [5:0] funct);
        return (funct == FN_MULT) || (funct == FN_DIV);
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// EX-stage request/response bundle between the decode logic and the MDU.
interface mult_div_unit_if #(parameter int WIDTH = 32);

    logic             start;
    logic [5:0]       funct;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             stall;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, funct, op_a, op_b,
        input  busy, stall, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, funct, op_a, op_b,
        output busy, stall, done, div_by_zero, hi, lo
    );

endinterface

// File: rtl/mult_div_unit_datapath.sv
// Shared shift/add-sub datapath: 2*WIDTH accumulator, one WIDTH+1 bit adder
// used for shift-add multiply and restoring divide, plus result sign fixup.
module mult_div_unit_datapath #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             is_div_i,
    input  logic             neg_res_i,
    input  logic             neg_rem_i,
    input  logic [WIDTH-1:0] ld_hi_i,
    input  logic [WIDTH-1:0] ld_lo_i,
    input  logic [WIDTH-1:0] ld_opnd_i,
    output logic [WIDTH-1:0] res_hi_o,
    output logic [WIDTH-1:0] res_lo_o
);

    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [2*WIDTH-1:0] acc_neg_s;
    logic [WIDTH-1:0]   opnd_q;
    logic [WIDTH-1:0]   acc_hi_s;
    logic [WIDTH-1:0]   acc_lo_s;
    logic [WIDTH:0]     add_a_s;
    logic [WIDTH:0]     add_b_s;
    logic [WIDTH:0]     sum_s;

    // One iteration: divide subtracts from the shifted remainder, multiply adds the multiplicand
    always_comb begin
        acc_hi_s = acc_q[2*WIDTH-1:WIDTH];
        acc_lo_s = acc_q[WIDTH-1:0];
        if (is_div_i) begin
            add_a_s = {acc_hi_s, acc_lo_s[WIDTH-1]};
            add_b_s = ~{1'b0, opnd_q};
        end else begin
            add_a_s = {1'b0, acc_hi_s};
            add_b_s = {1'b0, opnd_q};
        end
        sum_s = add_a_s + add_b_s + {{WIDTH{1'b0}}, is_div_i};
        if (is_div_i) begin
            // sum_s[WIDTH] set means the trial subtract borrowed: restore
            if (!sum_s[WIDTH]) begin
                acc_d = {sum_s[WIDTH-1:0], acc_lo_s[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = {add_a_s[WIDTH-1:0], acc_lo_s[WIDTH-2:0], 1'b0};
            end
        end else if (acc_lo_s[0]) begin
            acc_d = {sum_s, acc_lo_s[WIDTH-1:1]};
        end else begin
            acc_d = {1'b0, acc_hi_s, acc_lo_s[WIDTH-1:1]};
        end
    end

    // Sign fixup of the magnitude result
    always_comb begin
        acc_neg_s = -acc_q;
        if (is_div_i) begin
            res_lo_o = neg_res_i ? -acc_lo_s : acc_lo_s;
            res_hi_o = neg_rem_i ? -acc_hi_s : acc_hi_s;
        end else if (neg_res_i) begin
            {res_hi_o, res_lo_o} = acc_neg_s;
        end else begin
            {res_hi_o, res_lo_o} = acc_q;
        end
    end

    // Accumulator and operand registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_q  <= {(2*WIDTH){1'b0}};
            opnd_q <= {WIDTH{1'b0}};
        end else if (load_i) begin
            acc_q  <= {ld_hi_i, ld_lo_i};
            opnd_q <= ld_opnd_i;
        end else if (step_i) begin
            acc_q  <= acc_d;
        end else begin
            acc_q  <= acc_q;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU controller for the EX stage; owns HI/LO,
// sequences the shared datapath and holds EX while an operation is running.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    mult_div_unit_if.slave mdu
);

    localparam int CW = $clog2(WIDTH);

    mdu_state_e       state_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;
    logic             dbz_pend_q;
    logic             div_mode_q;
    logic             neg_res_q;
    logic             neg_rem_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic             is_mul_s;
    logic             is_div_s;
    logic             sgn_s;
    logic             b_zero_s;
    logic             load_s;
    logic             step_s;
    logic [WIDTH-1:0] mag_a_s;
    logic [WIDTH-1:0] mag_b_s;
    logic [WIDTH-1:0] ld_hi_s;
    logic [WIDTH-1:0] ld_lo_s;
    logic [WIDTH-1:0] ld_opnd_s;
    logic [WIDTH-1:0] res_hi_s;
    logic [WIDTH-1:0] res_lo_s;

    // Request decode and operand magnitudes for the datapath load
    always_comb begin
        is_mul_s = mdu.start && ((mdu.funct == FN_MULT) || (mdu.funct == FN_MULTU));
        is_div_s = mdu.start && ((mdu.funct == FN_DIV) || (mdu.funct == FN_DIVU));
        sgn_s    = is_signed_op(mdu.funct);
        b_zero_s = (mdu.op_b == {WIDTH{1'b0}});
        mag_a_s  = (sgn_s && mdu.op_a[WIDTH-1]) ? -mdu.op_a : mdu.op_a;
        mag_b_s  = (sgn_s && mdu.op_b[WIDTH-1]) ? -mdu.op_b : mdu.op_b;
        load_s   = (state_q == ST_IDLE) && (is_mul_s || is_div_s);
        step_s   = (state_q == ST_MUL) || (state_q == ST_DIV);
        if (is_mul_s) begin
            ld_hi_s   = {WIDTH{1'b0}};
            ld_lo_s   = mag_b_s;
            ld_opnd_s = mag_a_s;
        end else if (b_zero_s) begin
            // Divide by zero preloads the final answer; fixup passes it through
            ld_hi_s   = mdu.op_a;
            ld_lo_s   = {WIDTH{1'b1}};
            ld_opnd_s = {WIDTH{1'b0}};
        end else begin
            ld_hi_s   = {WIDTH{1'b0}};
            ld_lo_s   = mag_a_s;
            ld_opnd_s = mag_b_s;
        end
    end

    assign mdu.stall       = mdu.start && (busy_q || (state_q != ST_IDLE));
    assign mdu.busy        = busy_q;
    assign mdu.done        = done_q;
    assign mdu.div_by_zero = dbz_q;
    assign mdu.hi          = hi_q;
    assign mdu.lo          = lo_q;

    mult_div_unit_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk       (clk),
        .reset_n   (reset_n),
        .load_i    (load_s),
        .step_i    (step_s),
        .is_div_i  (div_mode_q),
        .neg_res_i (neg_res_q),
        .neg_rem_i (neg_rem_q),
        .ld_hi_i   (ld_hi_s),
        .ld_lo_i   (ld_lo_s),
        .ld_opnd_i (ld_opnd_s),
        .res_hi_o  (res_hi_s),
        .res_lo_o  (res_lo_s)
    );

    // Controller FSM, iteration counter, sign flags and HI/LO
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= {CW{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
            dbz_pend_q <= 1'b0;
            div_mode_q <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            hi_q       <= {WIDTH{1'b0}};
            lo_q       <= {WIDTH{1'b0}};
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (is_mul_s) begin
                        state_q    <= ST_MUL;
                        cnt_q      <= CW'(WIDTH - 1);
                        busy_q     <= 1'b1;
                        div_mode_q <= 1'b0;
                        neg_res_q  <= sgn_s && (mdu.op_a[WIDTH-1] ^ mdu.op_b[WIDTH-1]);
                        neg_rem_q  <= 1'b0;
                    end else if (is_div_s) begin
                        busy_q     <= 1'b1;
                        div_mode_q <= 1'b1;
                        cnt_q      <= CW'(WIDTH - 1);
                        if (b_zero_s) begin
                            state_q    <= ST_FIXUP;
                            dbz_pend_q <= 1'b1;
                            neg_res_q  <= 1'b0;
                            neg_rem_q  <= 1'b0;
                        end else begin
                            state_q   <= ST_DIV;
                            neg_res_q <= sgn_s && (mdu.op_a[WIDTH-1] ^ mdu.op_b[WIDTH-1]);
                            neg_rem_q <= sgn_s && mdu.op_a[WIDTH-1];
                        end
                    end else if (mdu.start && (mdu.funct == FN_MTHI)) begin
                        hi_q <= mdu.op_a;
                    end else if (mdu.start && (mdu.funct == FN_MTLO)) begin
                        lo_q <= mdu.op_a;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (cnt_q == {CW{1'b0}}) begin
                        state_q <= ST_FIXUP;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ST_FIXUP: begin
                    hi_q       <= res_hi_s;
                    lo_q       <= res_lo_s;
                    done_q     <= 1'b1;
                    dbz_q      <= dbz_pend_q;
                    dbz_pend_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases, randomized ops
// against a plain-arithmetic reference model, stall and reset scenarios.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    mult_div_unit_if #(.WIDTH(32)) mdu ();

    mult_div_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .mdu     (mdu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: 64-bit integer arithmetic, truncating division
    task automatic ref_model(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] eh, output logic [31:0] el,
                             output logic ez, output int lat);
        longint      sa, sb, p, q, r;
        logic [63:0] up;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ez  = 1'b0;
        lat = 34;
        eh  = 32'h0;
        el  = 32'h0;
        if (fn == FN_MULT) begin
            p  = sa * sb;
            eh = p[63:32];
            el = p[31:0];
        end else if (fn == FN_MULTU) begin
            up = {32'h0, a} * {32'h0, b};
            eh = up[63:32];
            el = up[31:0];
        end else if (b == 32'h0) begin
            eh  = a;
            el  = 32'hFFFFFFFF;
            ez  = 1'b1;
            lat = 2;
        end else if (fn == FN_DIV) begin
            q  = sa / sb;
            r  = sa % sb;
            el = q[31:0];
            eh = r[31:0];
        end else begin
            el = a / b;
            eh = a % b;
        end
    endtask

    // Present a request for one edge; returns at the negedge of cycle 1
    task automatic issue(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        mdu.start = 1'b1;
        mdu.funct = fn;
        mdu.op_a  = a;
        mdu.op_b  = b;
        @(negedge clk);
        mdu.start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int lat);
        int cyc;
        int nbusy;
        cyc   = 1;
        nbusy = 0;
        while (!mdu.done && cyc < 60) begin
            if (mdu.busy) nbusy++;
            @(negedge clk);
            cyc++;
        end
        check_eq({tag, "_lat"}, 64'(cyc), 64'(lat));
        check_eq({tag, "_busycnt"}, 64'(nbusy), 64'(lat - 1));
        check_eq({tag, "_busy_at_done"}, 64'(mdu.busy), 64'(0));
    endtask

    task automatic run_op(input string tag, input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eh, el;
        logic        ez;
        int          lat;
        ref_model(fn, a, b, eh, el, ez, lat);
        issue(fn, a, b);
        wait_done(tag, lat);
        check_eq({tag, "_hi"}, 64'(mdu.hi), 64'(eh));
        check_eq({tag, "_lo"}, 64'(mdu.lo), 64'(el));
        check_eq({tag, "_dbz"}, 64'(mdu.div_by_zero), 64'(ez));
        @(negedge clk);
        check_eq({tag, "_done_pulse"}, 64'(mdu.done), 64'(0));
    endtask

    task automatic move_to(input logic [5:0] fn, input logic [31:0] v);
        issue(fn, v, 32'h0);
    endtask

    logic [5:0]  fns [4] = '{FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};
    logic [31:0] ra, rb;
    logic [5:0]  rf;
    int          cyc;
    int          ndone;

    initial begin
        total = 0;
        bad   = 0;
        reset_n   = 1'b0;
        mdu.start = 1'b0;
        mdu.funct = 6'b0;
        mdu.op_a  = 32'h0;
        mdu.op_b  = 32'h0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 64'(mdu.busy), 64'(0));
        check_eq("rst_done", 64'(mdu.done), 64'(0));
        check_eq("rst_dbz", 64'(mdu.div_by_zero), 64'(0));
        check_eq("rst_hi", 64'(mdu.hi), 64'(0));
        check_eq("rst_lo", 64'(mdu.lo), 64'(0));
        check_eq("rst_stall", 64'(mdu.stall), 64'(0));
        reset_n = 1'b1;

        run_op("mult_7_m3", FN_MULT, 32'd7, 32'hFFFFFFFD);
        run_op("multu_max", FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op("div_m7_2", FN_DIV, 32'hFFFFFFF9, 32'd2);
        run_op("divu_100_7", FN_DIVU, 32'd100, 32'd7);
        run_op("divu_by0", FN_DIVU, 32'h1234, 32'h0);
        run_op("div_ovf", FN_DIV, 32'h80000000, 32'hFFFFFFFF);
        run_op("div_by0_neg", FN_DIV, 32'h80000001, 32'h0);

        // Randomized ops with interleaved HI/LO moves
        for (int i = 0; i < 30; i++) begin
            rf = fns[$urandom_range(0, 3)];
            ra = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'h0;
                1: rb = 32'hFFFFFFFF;
                2: rb = 32'($urandom_range(1, 9));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) ra = 32'h80000000;
            run_op($sformatf("rnd%0d", i), rf, ra, rb);
            if ($urandom_range(0, 3) == 0) begin
                ra = $urandom;
                move_to(FN_MTHI, ra);
                check_eq("rnd_mthi", 64'(mdu.hi), 64'(ra));
            end
        end

        // MTLO in IDLE and non-stalling MFHI
        move_to(FN_MTLO, 32'hABCD);
        check_eq("mtlo_lo", 64'(mdu.lo), 64'(32'hABCD));
        check_eq("mtlo_done", 64'(mdu.done), 64'(0));
        check_eq("mtlo_busy", 64'(mdu.busy), 64'(0));
        mdu.start = 1'b1;
        mdu.funct = FN_MFHI;
        #1;
        check_eq("mfhi_idle_stall", 64'(mdu.stall), 64'(0));
        mdu.start = 1'b0;

        // Request during a running MULT is stalled, then accepted on the done cycle
        move_to(FN_MTHI, 32'h1111);
        move_to(FN_MTLO, 32'h2222);
        issue(FN_MULT, 32'd3, 32'd5);
        cyc = 1;
        while (!mdu.done && cyc < 60) begin
            if (cyc == 5) begin
                mdu.start = 1'b1;
                mdu.funct = FN_MULT;
                mdu.op_a  = 32'd6;
                mdu.op_b  = 32'd7;
                #1;
                check_eq("stall_mult", 64'(mdu.stall), 64'(1));
                check_eq("stall_hi_keep", 64'(mdu.hi), 64'(32'h1111));
                check_eq("stall_lo_keep", 64'(mdu.lo), 64'(32'h2222));
            end
            if (cyc == 6) begin
                mdu.funct = FN_MFHI;
                #1;
                check_eq("stall_mfhi", 64'(mdu.stall), 64'(1));
                mdu.funct = FN_MULT;
            end
            @(negedge clk);
            cyc++;
        end
        check_eq("stall_first_lat", 64'(cyc), 64'(34));
        check_eq("stall_first_lo", 64'(mdu.lo), 64'(15));
        check_eq("stall_done_cycle_stall", 64'(mdu.stall), 64'(0));
        @(negedge clk);
        mdu.start = 1'b0;
        wait_done("stall_second", 34);
        check_eq("stall_second_hi", 64'(mdu.hi), 64'(0));
        check_eq("stall_second_lo", 64'(mdu.lo), 64'(42));

        // Reset in the middle of a MULT abandons it
        move_to(FN_MTHI, 32'h5555);
        issue(FN_MULT, 32'd9, 32'd9);
        repeat (9) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check_eq("midrst_busy", 64'(mdu.busy), 64'(0));
        check_eq("midrst_hi", 64'(mdu.hi), 64'(0));
        check_eq("midrst_lo", 64'(mdu.lo), 64'(0));
        reset_n = 1'b1;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (mdu.done) ndone++;
        end
        check_eq("midrst_no_done", 64'(ndone), 64'(0));
        check_eq("midrst_busy_after", 64'(mdu.busy), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
